// File: rtl/sm83_bus_seq.sv
// rtl/sm83_bus_seq.sv - M-cycle bus sequencer: priority arbitration, wait states, timeout
// A free-running T-cycle counter frames M-cycles; memory stalls stretch the last T-cycle.
module sm83_bus_seq #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int T_PER_M  = 4,
  parameter int WAIT_MAX = 15,
  parameter int N_REQ    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_ren,
  output logic                     mem_wen,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ready,
  output logic                     m_tick
);

  localparam int T_CNT_W = $clog2(T_PER_M);
  localparam int WC_W    = $clog2(WAIT_MAX + 1);
  localparam int GNT_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [T_CNT_W-1:0] T_LAST = T_CNT_W'(T_PER_M - 1);
  localparam logic [WC_W-1:0]    WC_MAX = WC_W'(WAIT_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT} state_e;

  state_e              state_q, state_d;
  logic [T_CNT_W-1:0]  t_cnt_q, t_cnt_d;
  logic [WC_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [GNT_W-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [GNT_W-1:0]    win;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_we;
  logic                busy, last_t, stall, sample, grant_en;

  always_comb begin
    win       = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    // Later (higher) indices overwrite earlier ones, giving fixed priority to the top index.
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i]) begin
        win       = GNT_W'(i);
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_we    = req_we[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;

    busy     = (state_q != ST_IDLE);
    last_t   = (t_cnt_q == T_LAST);
    stall    = busy && !mem_ready && (wait_cnt_q < WC_MAX);
    sample   = (state_q == ST_WAIT) || ((state_q == ST_ACCESS) && last_t);
    grant_en = rst_n && !busy && (t_cnt_q == '0) && (|req_valid);

    t_cnt_d = last_t ? (stall ? t_cnt_q : '0) : t_cnt_q + T_CNT_W'(1);
    m_tick  = last_t && !stall;

    if (grant_en) begin
      req_ready[win] = 1'b1;
      addr_d         = sel_addr;
      wdata_d        = sel_wdata;
      we_d           = sel_we;
      gnt_d          = win;
      wait_cnt_d     = '0;
      state_d        = ST_ACCESS;
    end

    if (sample) begin
      if (mem_ready || (wait_cnt_q == WC_MAX)) begin
        state_d            = ST_IDLE;
        rsp_valid_d[gnt_q] = 1'b1;
        rsp_err_d          = !mem_ready;
        rsp_rdata_d        = !mem_ready ? '1 : (we_q ? '0 : mem_rdata);
      end else begin
        state_d    = ST_WAIT;
        wait_cnt_d = wait_cnt_q + WC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      t_cnt_q     <= '0;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_cnt_q     <= t_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ren   = busy && !we_q;
  assign mem_wen   = busy && we_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sm83_bus_seq.sv
// tb/tb_sm83_bus_seq.sv - directed vector bench for sm83_bus_seq
// Cycle 0 of every transaction is a t_cnt==0 cycle; inputs change 1ns after posedge, outputs sampled at negedge.
module tb_sm83_bus_seq;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int T_PER_M  = 4;
  localparam int WAIT_MAX = 3;
  localparam int N_REQ    = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_we = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [N_REQ*DATA_W-1:0] req_wdata = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    rsp_err;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_ren;
  logic                    mem_wen;
  logic [DATA_W-1:0]       mem_rdata = '0;
  logic                    mem_ready = 1'b0;
  logic                    m_tick;

  int n_chk = 0;
  int n_fail = 0;

  sm83_bus_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_PER_M(T_PER_M), .WAIT_MAX(WAIT_MAX), .N_REQ(N_REQ)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .m_tick(m_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  // stall: cycles of mem_ready=0 after the last T-cycle; -1 means memory never answers
  typedef struct {
    logic        we;
    int          idx;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          stall;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    int          exp_rsp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int cyc);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic v, input logic we, input logic [15:0] a, input logic [7:0] d);
    req_valid[idx]           = v;
    req_we[idx]              = we;
    req_addr[idx*16 +: 16]   = a;
    req_wdata[idx*8 +: 8]    = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0, -1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0, -1);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0, -1);
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0, -1);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0, -1);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0, -1);
    chk({tag, "_mem_ren"},   32'(mem_ren),   32'd0, -1);
    chk({tag, "_mem_wen"},   32'(mem_wen),   32'd0, -1);
    chk({tag, "_m_tick"},    32'(m_tick),    32'd0, -1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] onehot;
    logic       strobe;
    onehot        = '0;
    onehot[v.idx] = 1'b1;
    set_req(v.idx, 1'b1, v.we, v.addr, v.wdata);
    mem_rdata = v.rdata;
    for (int c = 0; c <= v.exp_rsp + 3; c++) begin
      if (c > 0) req_valid = '0;
      mem_ready = (c < 3) || (v.stall >= 0 && c >= 3 + v.stall);
      @(negedge clk);
      strobe = (c >= 1) && (c < v.exp_rsp);
      chk("req_ready", 32'(req_ready), 32'(c == 0 ? onehot : 2'b00), c);
      chk("mem_ren", 32'(mem_ren), 32'(strobe && !v.we), c);
      chk("mem_wen", 32'(mem_wen), 32'(strobe && v.we), c);
      if (strobe) begin
        chk("mem_addr", 32'(mem_addr), 32'(v.addr), c);
        if (v.we) chk("mem_wdata", 32'(mem_wdata), 32'(v.wdata), c);
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(c == v.exp_rsp ? onehot : 2'b00), c);
      if (c == v.exp_rsp) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata), c);
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err), c);
      end
      chk("m_tick", 32'(m_tick), 32'(c == v.exp_rsp - 1 || c == v.exp_rsp + 3), c);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    //         we    idx addr      wdata  rdata  stall exp_rd err   rsp
    vecs[0] = '{1'b0, 0, 16'h0150, 8'h00, 8'h3E,  0,   8'h3E, 1'b0, 4};
    vecs[1] = '{1'b1, 0, 16'hC000, 8'h5A, 8'h77,  0,   8'h00, 1'b0, 4};
    vecs[2] = '{1'b0, 1, 16'hFE00, 8'h00, 8'hA5,  2,   8'hA5, 1'b0, 6};
    vecs[3] = '{1'b0, 0, 16'h8000, 8'h00, 8'h12, -1,   8'hFF, 1'b1, 7};
    vecs[4] = '{1'b1, 1, 16'hFF46, 8'h81, 8'h66,  1,   8'h00, 1'b0, 5};
    vecs[5] = '{1'b1, 1, 16'h2000, 8'h11, 8'h22, -1,   8'hFF, 1'b1, 7};
    vecs[6] = '{1'b0, 0, 16'h4321, 8'h00, 8'hC3,  3,   8'hC3, 1'b0, 7};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Collision: req1 wins, req0 keeps asking and is granted on the completion cycle.
    set_req(1, 1'b1, 1'b0, 16'hFE00, 8'h00);
    set_req(0, 1'b1, 1'b0, 16'hC000, 8'h00);
    mem_ready = 1'b1;
    mem_rdata = 8'h42;
    for (int c = 0; c < 12; c++) begin
      if (c >= 1) req_valid[1] = 1'b0;
      if (c >= 5) req_valid[0] = 1'b0;
      @(negedge clk);
      chk("col_req_ready", 32'(req_ready), 32'(c == 0 ? 2'b10 : (c == 4 ? 2'b01 : 2'b00)), c);
      chk("col_rsp_valid", 32'(rsp_valid), 32'(c == 4 ? 2'b10 : (c == 8 ? 2'b01 : 2'b00)), c);
      chk("col_mem_ren", 32'(mem_ren), 32'((c >= 1 && c <= 3) || (c >= 5 && c <= 7)), c);
      if ((c >= 1 && c <= 3) || (c >= 5 && c <= 7))
        chk("col_mem_addr", 32'(mem_addr), 32'(c < 4 ? 16'hFE00 : 16'hC000), c);
      if (c == 4 || c == 8) chk("col_rsp_rdata", 32'(rsp_rdata), 32'h42, c);
      chk("col_m_tick", 32'(m_tick), 32'(c % 4 == 3), c);
      @(posedge clk);
      #1;
    end

    // Reset during a stalled read: the read must vanish without a response.
    set_req(0, 1'b1, 1'b0, 16'h8000, 8'h00);
    mem_ready = 1'b0;
    mem_rdata = 8'h99;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) req_valid = '0;
      @(negedge clk);
      chk("rst_mem_ren", 32'(mem_ren), 32'(c >= 1), c);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0, c);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    chk_all_zero("midrst_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
